// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one BLOCK-bit
//   slice per clock. Each slice evaluates both borrow-in candidates in
//   parallel and the running borrow picks one, as in a carry-select stage.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, only looked at while not busy (IDLE or DONE)
//   a, b  : minuend / subtrahend, latched on the accepting edge
//   bin   : borrow-in, latched on the accepting edge
//   busy  : high while slices are being processed
//   done  : one-cycle pulse when diff/bout/ovf are valid
//   diff  : a - b - bin modulo 2^WIDTH
//   bout  : borrow-out (unsigned a < b + bin)
//   ovf   : signed overflow of the subtraction
module block_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NBLK  = WIDTH / BLOCK;
  localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBLK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Returns {borrow, difference} of x - y - bi over one slice.
  function automatic logic [BLOCK:0] blk_sub(input logic [BLOCK-1:0] x,
                                             input logic [BLOCK-1:0] y,
                                             input logic             bi);
    return {1'b0, x} - {1'b0, y} - {{BLOCK{1'b0}}, bi};
  endfunction

  // Signed overflow: operands differ in sign and result sign differs from a.
  function automatic logic ovf_calc(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] d);
    return (x[WIDTH-1] ^ y[WIDTH-1]) & (d[WIDTH-1] ^ x[WIDTH-1]);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [BLOCK-1:0] w_ablk;
  logic [BLOCK-1:0] w_bblk;
  logic [BLOCK:0]   w_d0;
  logic [BLOCK:0]   w_d1;
  logic [BLOCK:0]   w_sel;
  logic [WIDTH-1:0] w_diff_next;

  // Accept start only when not processing; DONE also accepts for back-to-back.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST_CNT);

  // Slice selection from the latched operands.
  always_comb begin
    w_ablk = '0;
    w_bblk = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_ablk = r_a[k*BLOCK +: BLOCK];
        w_bblk = r_b[k*BLOCK +: BLOCK];
      end
    end
  end

  // Both borrow-in candidates in parallel; running borrow selects.
  assign w_d0  = blk_sub(w_ablk, w_bblk, 1'b0);
  assign w_d1  = blk_sub(w_ablk, w_bblk, 1'b1);
  assign w_sel = r_borrow ? w_d1 : w_d0;

  // Diff with the current slice merged in, so ovf sees the complete result
  // on the final slice.
  always_comb begin
    w_diff_next = r_diff;
    for (int k = 0; k < NBLK; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_diff_next[k*BLOCK +: BLOCK] = w_sel[BLOCK-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control state; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  // Operand latch and slice datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_diff   <= w_diff_next;
      r_borrow <= w_sel[BLOCK];
      if (w_last) begin
        r_cnt  <= '0;
        r_bout <= w_sel[BLOCK];
        r_ovf  <= ovf_calc(r_a, r_b, w_diff_next);
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Testbench for block_serial_subtractor: directed vectors, expected results
// queued at issue time and checked by an independent monitor on done.
module tb_block_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  always #5 clk = ~clk;

  block_serial_subtractor #(.WIDTH(16), .BLOCK(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   busy_run = 0;
  int   ncyc = 0;
  int   last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (busy && done) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
    end
    if (done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected done=0");
      end else begin
        e = q.pop_front();
        check("diff", {16'd0, diff}, {16'd0, e.d});
        check("bout", {31'd0, bout}, {31'd0, e.bo});
        check("ovf", {31'd0, ovf}, {31'd0, e.ov});
        check("busy_cycles", busy_run, 4);
      end
      n_done++;
      last_done_cyc = ncyc;
    end
    busy_run = busy ? busy_run + 1 : 0;
    ncyc++;
  end

  task automatic wait_done(input int target, input string name);
    int waited = 0;
    while (n_done < target && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (n_done < target) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d dones, expected %0d", name, n_done, target);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ibin,
                        input logic [15:0] ed, input logic ebo, input logic eov);
    int t = n_done + 1;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    q.push_back('{d: ed, bo: ebo, ov: eov});
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, "_busy_after_start"}, {31'd0, busy}, 1);
    wait_done(t, name);
  endtask

  task automatic check_zero(input string name);
    check({name, "_diff"}, {16'd0, diff}, 0);
    check({name, "_bout"}, {31'd0, bout}, 0);
    check({name, "_ovf"}, {31'd0, ovf}, 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    int t;
    int d1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_op("op543m123",  16'd543,   16'd123,   1'b0, 16'd420,   1'b0, 1'b0);
    run_op("op123m543",  16'd123,   16'd543,   1'b1, 16'hFE5B,  1'b1, 1'b0);
    run_op("op0m0b1",    16'h0000,  16'h0000,  1'b1, 16'hFFFF,  1'b1, 1'b0);
    run_op("op7fffmffff",16'h7FFF,  16'hFFFF,  1'b0, 16'h8000,  1'b1, 1'b1);
    run_op("op8000m1",   16'h8000,  16'h0001,  1'b0, 16'h7FFF,  1'b0, 1'b1);
    run_op("opa5a5",     16'hA5A5,  16'h5A5A,  1'b0, 16'h4B4B,  1'b0, 1'b1);
    run_op("opffffm0b1", 16'hFFFF,  16'h0000,  1'b1, 16'hFFFE,  1'b0, 1'b0);

    // Second start while busy must be ignored.
    t = n_done + 1;
    @(negedge clk);
    a = 16'd32000; b = 16'd20; bin = 1'b0; start = 1'b1;
    q.push_back('{d: 16'd31980, bo: 1'b0, ov: 1'b0});
    @(negedge clk);
    start = 1'b0; a = 16'd1111; b = 16'd2222; bin = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t, "ignore_busy_start");

    // Reset two cycles into an operation aborts it.
    t = n_done;
    @(negedge clk);
    a = 16'd1000; b = 16'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("abort");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("no_done_after_abort", n_done, t);

    // Start held high across two operations.
    t = n_done;
    @(negedge clk);
    a = 16'd256; b = 16'd256; bin = 1'b0; start = 1'b1;
    q.push_back('{d: 16'd0, bo: 1'b0, ov: 1'b0});
    @(negedge clk);
    #1;
    a = 16'd4566; b = 16'd20;
    q.push_back('{d: 16'd4546, bo: 1'b0, ov: 1'b0});
    wait_done(t + 1, "held_first");
    d1 = last_done_cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(t + 2, "held_second");
    check("done_spacing", last_done_cyc - d1, 5);

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
